// File: rtl/osc_freq_monitor_pkg.sv
// rtl/osc_freq_monitor_pkg.sv - shared types and helpers for the oscillator frequency monitor
package osc_freq_monitor_pkg;

  typedef enum logic [1:0] {
    CH_FAIL = 2'd0,
    CH_QUAL = 2'd1,
    CH_OK   = 2'd2
  } ch_state_t;

  // Wide enough for QUAL_WIN up to 15
  localparam int QUAL_CNT_W = 4;

  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/osc_freq_monitor_chan.sv
// rtl/osc_freq_monitor_chan.sv - per-channel synchroniser, edge counter and health state machine
// Counts synchronised rising edges over one window and qualifies the count against cfg bounds.
module osc_freq_monitor_chan
  import osc_freq_monitor_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int QUAL_WIN = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             term_i,
  input  logic             osc_i,
  input  logic [CNT_W-1:0] cfg_lo_i,
  input  logic [CNT_W-1:0] cfg_hi_i,
  output logic [CNT_W-1:0] meas_cnt_o,
  output logic             ok_next_o,
  output logic             ch_ok_o
);

  localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [QUAL_CNT_W-1:0] QUAL_ONE  = QUAL_CNT_W'(1);
  localparam logic [QUAL_CNT_W-1:0] QUAL_LAST = QUAL_CNT_W'(QUAL_WIN);

  logic                  sync1_q, sync2_q, dly_q;
  logic                  rise, in_bound;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]      meas_q;
  logic                  ok_q;
  ch_state_t             state_q, state_d;
  logic [QUAL_CNT_W-1:0] qual_q, qual_d;

  assign rise     = sync2_q & ~dly_q;
  // Saturating count that already includes an edge seen on the terminal cycle
  assign cnt_inc  = (rise && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
  assign in_bound = (cfg_lo_i <= cnt_inc) && (cnt_inc <= cfg_hi_i);

  always_comb begin
    cnt_d = cnt_inc;
    if (!en_i || term_i) cnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    if (term_i) begin
      unique case (state_q)
        CH_FAIL: begin
          if (in_bound) begin
            if (QUAL_WIN == 1) begin
              state_d = CH_OK;
            end else begin
              state_d = CH_QUAL;
              qual_d  = QUAL_ONE;
            end
          end
        end
        CH_QUAL: begin
          if (in_bound) begin
            qual_d = qual_q + QUAL_ONE;
            if (qual_d == QUAL_LAST) begin
              state_d = CH_OK;
              qual_d  = '0;
            end
          end else begin
            state_d = CH_FAIL;
            qual_d  = '0;
          end
        end
        CH_OK: begin
          if (!in_bound) state_d = CH_FAIL;
        end
        default: begin
          state_d = CH_FAIL;
          qual_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      cnt_q   <= '0;
      meas_q  <= '0;
      ok_q    <= 1'b0;
      state_q <= CH_FAIL;
      qual_q  <= '0;
    end else begin
      sync1_q <= osc_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      qual_q  <= qual_d;
      if (term_i) begin
        meas_q <= cnt_inc;
        ok_q   <= (state_d == CH_OK);
      end
    end
  end

  assign meas_cnt_o = meas_q;
  assign ok_next_o  = (state_d == CH_OK);
  assign ch_ok_o    = ok_q;

endmodule

// File: rtl/osc_freq_monitor.sv
// rtl/osc_freq_monitor.sv - multi-channel oscillator health monitor with healthy-channel selector
// Optional sticky failure interrupt enabled by defining OSC_FREQ_MONITOR_IRQ_EN.
module osc_freq_monitor
  import osc_freq_monitor_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int CNT_W    = 16,
  parameter int WINDOW   = 50000,
  parameter int QUAL_WIN = 2,
  localparam int SEL_W   = sel_width(NUM_CH)
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       osc_in,
  input  logic [NUM_CH*CNT_W-1:0] cfg_lo,
  input  logic [NUM_CH*CNT_W-1:0] cfg_hi,
  output logic [NUM_CH*CNT_W-1:0] meas_cnt,
  output logic [NUM_CH-1:0]       ch_ok,
  output logic                    any_ok,
  output logic [SEL_W-1:0]        sel,
  output logic                    window_done,
  output logic                    sel_change
`ifdef OSC_FREQ_MONITOR_IRQ_EN
  ,
  input  logic                    irq_clr,
  output logic [NUM_CH-1:0]       fail_sticky,
  output logic                    irq
`endif
);

  localparam int               WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

  logic [WIN_W-1:0]  win_q, win_d;
  logic              term;
  logic [NUM_CH-1:0] ok_next;
  logic [SEL_W-1:0]  sel_q, sel_next;
  logic              any_ok_q, sel_change_q;

  assign term = en && (win_q == WIN_LAST);

  always_comb begin
    win_d = win_q + WIN_ONE;
    if (!en || term) win_d = '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    osc_freq_monitor_chan #(
      .CNT_W   (CNT_W),
      .QUAL_WIN(QUAL_WIN)
    ) u_chan (
      .clk_i     (CLK),
      .rst_ni    (RESETN),
      .en_i      (en),
      .term_i    (term),
      .osc_i     (osc_in[i]),
      .cfg_lo_i  (cfg_lo[i*CNT_W +: CNT_W]),
      .cfg_hi_i  (cfg_hi[i*CNT_W +: CNT_W]),
      .meas_cnt_o(meas_cnt[i*CNT_W +: CNT_W]),
      .ok_next_o (ok_next[i]),
      .ch_ok_o   (ch_ok[i])
    );
  end

  // Lowest healthy index wins; with nothing healthy the previous choice is kept
  always_comb begin
    sel_next = sel_q;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ok_next[i]) sel_next = SEL_W'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      win_q        <= '0;
      sel_q        <= '0;
      any_ok_q     <= 1'b0;
      sel_change_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      sel_change_q <= 1'b0;
      if (term) begin
        any_ok_q     <= |ok_next;
        sel_q        <= sel_next;
        sel_change_q <= (sel_next != sel_q);
      end
    end
  end

  assign window_done = term;
  assign any_ok      = any_ok_q;
  assign sel         = sel_q;
  assign sel_change  = sel_change_q;

`ifdef OSC_FREQ_MONITOR_IRQ_EN
  logic [NUM_CH-1:0] fail_evt, sticky_q, sticky_d;
  logic              irq_q;

  // A channel can only leave OK for FAIL, so a registered OK with a non-OK next state is a drop
  assign fail_evt = {NUM_CH{term}} & ch_ok & ~ok_next;
  assign sticky_d = (irq_clr ? '0 : sticky_q) | fail_evt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      irq_q    <= |sticky_d;
    end
  end

  assign fail_sticky = sticky_q;
  assign irq         = irq_q;
`endif

endmodule

// File: tb/tb_osc_freq_monitor.sv
// tb/tb_osc_freq_monitor.sv - scoreboard bench for osc_freq_monitor (main and saturating instance)
module tb_osc_freq_monitor;

  localparam int NCH = 3;
  localparam int WIN = 100;
  localparam int QW  = 2;
  localparam int LO  = 9;
  localparam int HI  = 11;

  typedef struct packed {
    logic [23:0] meas;
    logic [2:0]  ok;
    logic        any;
    logic [1:0]  sel;
    logic        sc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        en;
  logic [2:0]  osc;
  logic        osc_sat;
  logic [23:0] meas;
  logic [2:0]  ok;
  logic        any_ok;
  logic [1:0]  sel;
  logic        wd, sc;
  logic [11:0] sat_meas;
  logic [2:0]  sat_ok;
  logic        sat_any, sat_wd, sat_sc;
  logic [1:0]  sat_sel;
`ifdef OSC_FREQ_MONITOR_IRQ_EN
  logic        irq_clr;
  logic [2:0]  fail_sticky, sat_sticky;
  logic        irq, sat_irq;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   tb_cyc;
  int   cur_n[3];
  exp_t exp_q[$];
  int   streak[3];
  logic [2:0]  m_ok, m_sticky;
  logic [1:0]  m_sel;
  logic [23:0] m_meas;

  always #5 CLK = ~CLK;

  osc_freq_monitor #(.NUM_CH(NCH), .CNT_W(8), .WINDOW(WIN), .QUAL_WIN(QW)) u_dut (
    .CLK(CLK), .RESETN(RESETN), .en(en), .osc_in(osc),
    .cfg_lo({3{8'd9}}), .cfg_hi({3{8'd11}}),
    .meas_cnt(meas), .ch_ok(ok), .any_ok(any_ok), .sel(sel),
    .window_done(wd), .sel_change(sc)
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    , .irq_clr(irq_clr), .fail_sticky(fail_sticky), .irq(irq)
`endif
  );

  osc_freq_monitor #(.NUM_CH(NCH), .CNT_W(4), .WINDOW(WIN), .QUAL_WIN(QW)) u_sat (
    .CLK(CLK), .RESETN(RESETN), .en(en), .osc_in({2'b00, osc_sat}),
    .cfg_lo({3{4'd9}}), .cfg_hi({3{4'd11}}),
    .meas_cnt(sat_meas), .ch_ok(sat_ok), .any_ok(sat_any), .sel(sat_sel),
    .window_done(sat_wd), .sel_change(sat_sc)
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    , .irq_clr(irq_clr), .fail_sticky(sat_sticky), .irq(sat_irq)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference window position: cycles since reset release / en rise, wrapping at WIN
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) tb_cyc <= 0;
    else if (!en || tb_cyc == WIN - 1) tb_cyc <= 0;
    else tb_cyc <= tb_cyc + 1;
  end

  // n pulses per window, all rising early enough to be counted inside the window
  function automatic logic pat(input int c, input int n);
    int sp, hi;
    sp = (n > 11) ? 3 : 8;
    hi = (n > 11) ? 1 : 4;
    if (c < 5 || n == 0) return 1'b0;
    return (((c - 5) / sp) < n) && (((c - 5) % sp) < hi);
  endfunction

  initial begin
    osc = '0;
    osc_sat = 1'b0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 3; i++) osc[i] = pat(tb_cyc, cur_n[i]);
      osc_sat = pat(tb_cyc, 25);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++) streak[i] = 0;
    m_ok = '0; m_sel = '0; m_meas = '0; m_sticky = '0;
  endtask

  task automatic run_window(input int n0, input int n1, input int n2, input int clr_at);
    int n[3];
    exp_t e;
    logic [2:0] prev_ok;
    logic [1:0] ns;
    n[0] = n0; n[1] = n1; n[2] = n2;
    prev_ok = m_ok;
    for (int i = 0; i < 3; i++) begin
      if (n[i] >= LO && n[i] <= HI) streak[i]++;
      else streak[i] = 0;
      m_ok[i] = (streak[i] >= QW);
      m_meas[i*8 +: 8] = 8'(n[i]);
    end
    e.sc = 1'b0;
    if (m_ok != 3'b000) begin
      ns = m_ok[0] ? 2'd0 : (m_ok[1] ? 2'd1 : 2'd2);
      e.sc = (ns != m_sel);
      m_sel = ns;
    end
    m_sticky = ((clr_at >= 0) ? 3'b000 : m_sticky) | (prev_ok & ~m_ok);
    e.meas = m_meas; e.ok = m_ok; e.any = |m_ok; e.sel = m_sel;
    exp_q.push_back(e);
    for (int i = 0; i < 3; i++) cur_n[i] = n[i];
    for (int c = 0; c < WIN; c++) begin
`ifdef OSC_FREQ_MONITOR_IRQ_EN
      irq_clr = (c == clr_at);
`endif
      @(negedge CLK);
    end
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    irq_clr = 1'b0;
    check_eq("fail_sticky", 32'(fail_sticky), 32'(m_sticky));
    check_eq("irq", 32'(irq), 32'(|m_sticky));
`endif
  endtask

  task automatic partial_window(input int n0, input int n1, input int n2, input int cycles);
    cur_n[0] = n0; cur_n[1] = n1; cur_n[2] = n2;
    repeat (cycles) @(negedge CLK);
  endtask

  // Scoreboard consumer: compare one record per window_done, one cycle after the pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (wd) begin
        check_eq("wd_cycle", 32'(tb_cyc), 32'(WIN - 1));
        @(negedge CLK);
        check_eq("wd_expected", 32'(exp_q.size() != 0), 32'd1);
        check_eq("wd_pulse", 32'(wd), 32'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("meas_cnt", 32'(meas), 32'(e.meas));
          check_eq("ch_ok", 32'(ok), 32'(e.ok));
          check_eq("any_ok", 32'(any_ok), 32'(e.any));
          check_eq("sel", 32'(sel), 32'(e.sel));
          check_eq("sel_change", 32'(sc), 32'(e.sc));
        end
        @(negedge CLK);
        check_eq("sel_change_once", 32'(sc), 32'd0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (sat_wd) begin
        @(negedge CLK);
        check_eq("sat_meas", 32'(sat_meas[3:0]), 32'd15);
        check_eq("sat_ok", 32'(sat_ok), 32'd0);
        check_eq("sat_any", 32'(sat_any), 32'd0);
        check_eq("sat_sel", 32'(sat_sel), 32'd0);
        check_eq("sat_sc", 32'(sat_sc), 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_meas"}, 32'(meas), 32'd0);
    check_eq({tag, "_ok"}, 32'(ok), 32'd0);
    check_eq({tag, "_any"}, 32'(any_ok), 32'd0);
    check_eq({tag, "_sel"}, 32'(sel), 32'd0);
    check_eq({tag, "_wd"}, 32'(wd), 32'd0);
    check_eq({tag, "_sc"}, 32'(sc), 32'd0);
    check_eq({tag, "_sat_meas"}, 32'(sat_meas), 32'd0);
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    check_eq({tag, "_sticky"}, 32'(fail_sticky), 32'd0);
    check_eq({tag, "_irq"}, 32'(irq), 32'd0);
`endif
  endtask

  initial begin
    RESETN = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) cur_n[i] = 0;
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    irq_clr = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RESETN = 1'b1;

    run_window(10, 9, 11, -1);
    run_window(10, 9, 11, -1);
    run_window(10, 8, 11, -1);
    run_window(10, 9, 11, -1);
    run_window(10, 9, 11, -1);
    run_window(0, 9, 11, -1);
    run_window(10, 9, 11, -1);
    run_window(10, 9, 11, -1);
    run_window(0, 9, 11, 50);
    run_window(0, 0, 0, 99);
    run_window(10, 12, 11, 20);
    run_window(10, 9, 11, -1);
    run_window(0, 9, 8, -1);

    partial_window(10, 9, 11, 50);
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    model_reset();
    @(negedge CLK);
    RESETN = 1'b1;
    run_window(9, 11, 10, -1);
    run_window(11, 10, 9, -1);

    partial_window(10, 9, 11, 40);
    en = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      check_eq("en_off_wd", 32'(wd), 32'd0);
    end
    check_eq("frozen_ok", 32'(ok), 32'(m_ok));
    check_eq("frozen_sel", 32'(sel), 32'(m_sel));
    check_eq("frozen_meas", 32'(meas), 32'(m_meas));
    check_eq("frozen_any", 32'(any_ok), 32'(|m_ok));
    en = 1'b1;
    run_window(10, 9, 11, -1);
    run_window(0, 9, 11, -1);

    repeat (3) @(negedge CLK);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/osc_freq_monitor.md
Name: osc_freq_monitor

Overview:
- Multi-channel oscillator health monitor. Runs on the on-chip RC oscillator clock.
- Counts rising edges of up to NUM_CH asynchronous oscillator outputs (XTL, 1 MHz RC, fabric-routed clocks) over a fixed reference window.
- Qualifies each channel against programmable frequency bounds.
- Selects the lowest-indexed healthy channel for downstream CCC/clock-mux control.

Parameters:
- NUM_CH, 3, number of monitored oscillator inputs (1..8).
- CNT_W, 16, edge-counter and bound width.
- WINDOW, 50000, reference window length in CLK cycles (1 ms at 50 MHz); must be ≥ 4.
- QUAL_WIN, 2, consecutive in-bound windows required before a channel is declared OK (1..15).

Ports:
- CLK  input  1  reference clock (RC oscillator, 50 MHz).
- RESETN  input  1  asynchronous active-low reset.
- en  input  1  monitor enable.
- osc_in  input  NUM_CH  asynchronous oscillator signals, each below CLK/2.
- cfg_lo  input  NUM_CH*CNT_W  per-channel minimum edge count (inclusive); channel i at bits [i*CNT_W +: CNT_W].
- cfg_hi  input  NUM_CH*CNT_W  per-channel maximum edge count (inclusive); same packing as cfg_lo.
- meas_cnt  output  NUM_CH*CNT_W  last completed window's edge count per channel.
- ch_ok  output  NUM_CH  per-channel healthy flag.
- any_ok  output  1  OR of ch_ok.
- sel  output  $clog2(NUM_CH) (min 1)  selected channel index.
- window_done  output  1  one-cycle pulse on the window terminal cycle.
- sel_change  output  1  one-cycle pulse when sel changes.

Behaviour:
- Reset (async, RESETN=0): all counters, meas_cnt, ch_ok, any_ok, sel, window_done and sel_change are 0; all channel states are FAIL; sync flops are 0.
- Input path: each osc_in passes through a 2-FF synchroniser plus a delay flop. A rising edge is synced=1 & delayed=0. Edge-to-count latency is 3 CLK.
- Window counter runs 0..WINDOW-1 while en=1. The terminal cycle is count == WINDOW-1.
- On the terminal cycle:
  - The edge count, including any edge detected that same cycle, is latched to meas_cnt.
  - The edge counter clears to 0.
  - window_done pulses.
  - Channel state machines and the selector update in the same cycle; results are visible the next cycle.
- Edge counter saturates at 2^CNT_W-1 and never wraps.
- Channel in-bound test: cfg_lo ≤ count ≤ cfg_hi, unsigned. cfg_lo > cfg_hi means the channel is never in-bound.
- Channel state machine (per channel), evaluated only on the terminal cycle:
  - FAIL: in-bound with QUAL_WIN=1 goes to OK; in-bound with QUAL_WIN>1 goes to QUAL with qual_cnt=1; otherwise stays in FAIL.
  - QUAL: in-bound increments qual_cnt and goes to OK when qual_cnt reaches QUAL_WIN; out-of-bound goes to FAIL and clears qual_cnt.
  - OK: out-of-bound goes to FAIL (a single bad window drops the channel); otherwise stays in OK.
  - ch_ok = (state == OK), registered.
- Selector: on the terminal cycle, next sel is the lowest index whose next state is OK.
  - If no channel will be OK, sel holds its value and any_ok=0.
  - sel_change pulses in the cycle sel changes value.
- en=0:
  - Window and edge counters are held at 0; window_done and sel_change stay 0.
  - Channel states, meas_cnt, ch_ok and sel are frozen.
  - Synchronisers keep running.
  - en rising starts a fresh window at count 0.
- cfg_lo and cfg_hi are sampled only on the terminal cycle. Changes mid-window apply at the next boundary.

Optional Feature:
- Macro OSC_FREQ_MONITOR_IRQ_EN.
- Defined:
  - Adds input irq_clr (1) and outputs fail_sticky (NUM_CH) and irq (1).
  - fail_sticky[i] sets on any OK→FAIL transition of channel i.
  - irq = |fail_sticky, registered.
  - irq_clr=1 clears all sticky bits. If a set and a clear land in the same cycle, the set wins.
  - All three signals reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package osc_freq_monitor_pkg holds:
  - ch_state_t enum {CH_FAIL=2'd0, CH_QUAL=2'd1, CH_OK=2'd2};
  - a function computing sel width as max(1, $clog2(NUM_CH)).
- Sub-module osc_freq_monitor_chan: one per channel, instantiated in a generate loop. It contains the synchroniser, edge detect, saturating counter, bound compare, state machine and qual counter.
- Top level keeps the shared window counter, selector and optional IRQ logic.

Test Plan:
- Bench configuration for all tests: NUM_CH=3, CNT_W=8, WINDOW=100, QUAL_WIN=2, all bounds 9..11, en=1.
- Qualification: ch0 square wave with period 10 CLK (10 edges/window) → meas_cnt[0]=10 after the 1st window_done; ch_ok[0]=1, any_ok=1, sel=0 only after the 2nd window_done.
- Bounds: ch1 period 11.1 CLK (9 edges) and ch2 period 9.1 CLK (11 edges) → both OK after 2 windows. Changing ch1 to 8 edges/window → ch_ok[1]=0 after the next window_done.
- Failover: ch0 OK and ch1 OK, sel=0; ch0 held low → at the next window_done meas_cnt[0]≈0, ch_ok[0]=0, sel=1, sel_change pulses once; QUAL_WIN windows after ch0 restarts → sel=0 again.
- Saturation: CNT_W=4, ch0 period 4 CLK (25 edges) → meas_cnt[0]=15 and no wrap; ch0 stays FAIL with bounds 9..11.
- Reset/enable: assert RESETN=0 at window cycle 50 → all outputs 0 asynchronously, and after release the first window_done comes 100 cycles later. Drop en for 30 cycles → no window_done and outputs frozen; window restarts from 0.
- IRQ (macro defined): ch0 OK→FAIL → fail_sticky=3'b001 and irq=1; irq_clr pulse → both return to 0. A simultaneous fail and clear leaves the bit set.
